// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: queues rasterizer pixels as frame-buffer writes and drains them over an
// Avalon-MM write master. A clear request fills the whole frame with one colour once every
// pixel queued ahead of it has been written.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   base_i                      frame buffer base byte address
//   pix_valid_i / pix_ready_o   pixel handshake
//   pix_x_i, pix_y_i            pixel column / row
//   pix_color_i                 pixel word {8'h0, B, G, R}
//   clear_start_i               single-cycle frame fill request
//   clear_color_i               fill word, sampled with clear_start_i
//   busy_o                      work pending or in flight
//   master_address_o            Avalon-MM write address (registered)
//   master_write_o              Avalon-MM write strobe (registered)
//   master_writedata_o          Avalon-MM write data (registered)
//   master_waitrequest_i        Avalon-MM slave stall
module fb_pixel_writer #(
  parameter int unsigned HRES  = 640,
  parameter int unsigned VRES  = 480,
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [25:0] base_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  input  logic [9:0]  pix_x_i,
  input  logic [8:0]  pix_y_i,
  input  logic [31:0] pix_color_i,
  input  logic        clear_start_i,
  input  logic [31:0] clear_color_i,
  output logic        busy_o,
  output logic [25:0] master_address_o,
  output logic        master_write_o,
  output logic [31:0] master_writedata_o,
  input  logic        master_waitrequest_i
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned Total = HRES * VRES;
  localparam int unsigned CW    = $clog2(Total + 1);

  typedef enum logic [1:0] {StRun, StClearWait, StClear} state_e;

  state_e state_q, state_d;

  // FIFO entry: {address, data}. The write in flight stays at the head until it completes.
  logic [57:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] rptr_nx, count;
  logic        empty, full, one_left;

  logic [25:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        mw_q, mw_d;

  logic [CW-1:0] fill_q, fill_d;
  logic [25:0]   cbase_q, cbase_d;
  logic [31:0]   ccolor_q, ccolor_d;

  logic        in_range, push, done;
  logic [25:0] lin, pix_addr, fill_off;

  assign rptr_nx  = rptr_q + {{AW{1'b0}}, 1'b1};
  assign count    = wptr_q - rptr_q;
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign one_left = (count == {{AW{1'b0}}, 1'b1});

  assign in_range = (32'(pix_x_i) < HRES) && (32'(pix_y_i) < VRES);
  assign lin      = 26'(pix_x_i) + 26'(HRES) * 26'(pix_y_i);
  assign pix_addr = base_i + {lin[22:0], 3'b000};
  assign fill_off = 26'({fill_q, 3'b000});

  assign pix_ready_o = (state_q == StRun) && !full;
  assign push        = pix_valid_i && pix_ready_o && in_range;
  assign done        = mw_q && !master_waitrequest_i;
  assign busy_o      = (state_q != StRun) || !empty || mw_q;

  assign master_address_o   = addr_q;
  assign master_write_o     = mw_q;
  assign master_writedata_o = data_q;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q + {{AW{1'b0}}, push};
    rptr_d   = rptr_q;
    mw_d     = mw_q;
    addr_d   = addr_q;
    data_d   = data_q;
    fill_d   = fill_q;
    cbase_d  = cbase_q;
    ccolor_d = ccolor_q;

    unique case (state_q)
      StRun, StClearWait: begin
        if (done) begin
          rptr_d = rptr_nx;
          // Chain straight onto the next entry so a zero-wait slave sees one write per cycle.
          if (!one_left) begin
            {addr_d, data_d} = mem_q[rptr_nx[AW-1:0]];
            mw_d             = 1'b1;
          end else begin
            mw_d = 1'b0;
          end
        end else if (!mw_q && !empty) begin
          {addr_d, data_d} = mem_q[rptr_q[AW-1:0]];
          mw_d             = 1'b1;
        end

        if (state_q == StRun && clear_start_i) begin
          cbase_d  = base_i;
          ccolor_d = clear_color_i;
          state_d  = StClearWait;
        end

        if (state_q == StClearWait && empty && !mw_q) begin
          fill_d  = '0;
          state_d = StClear;
        end
      end

      StClear: begin
        if (!mw_q || done) begin
          if (fill_q != CW'(Total)) begin
            addr_d = cbase_q + fill_off;
            data_d = ccolor_q;
            mw_d   = 1'b1;
            fill_d = fill_q + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            // Final fill write completed this cycle.
            mw_d    = 1'b0;
            fill_d  = '0;
            state_d = StRun;
          end
        end
      end

      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StRun;
      wptr_q   <= '0;
      rptr_q   <= '0;
      mw_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      fill_q   <= '0;
      cbase_q  <= '0;
      ccolor_q <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      mw_q     <= mw_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      fill_q   <= fill_d;
      cbase_q  <= cbase_d;
      ccolor_q <= ccolor_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= {pix_addr, pix_color_i};
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
module tb_fb_pixel_writer;

  localparam int unsigned HRES  = 640;
  localparam int unsigned VRES  = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TOTAL = HRES * VRES;

  logic        clk, rst_n;
  logic [25:0] base;
  logic        pix_valid, pix_ready;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [31:0] pix_color;
  logic        clear_start;
  logic [31:0] clear_color;
  logic        busy;
  logic [25:0] m_addr;
  logic        m_write;
  logic [31:0] m_data;
  logic        m_wait;

  fb_pixel_writer #(.HRES(HRES), .VRES(VRES), .DEPTH(DEPTH)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .base_i              (base),
    .pix_valid_i         (pix_valid),
    .pix_ready_o         (pix_ready),
    .pix_x_i             (pix_x),
    .pix_y_i             (pix_y),
    .pix_color_i         (pix_color),
    .clear_start_i       (clear_start),
    .clear_color_i       (clear_color),
    .busy_o              (busy),
    .master_address_o    (m_addr),
    .master_write_o      (m_write),
    .master_writedata_o  (m_data),
    .master_waitrequest_i(m_wait)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_wr = 0;
  int last_cyc = 0;
  logic [25:0] last_addr;
  logic [31:0] last_data;
  logic [57:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: byte address = base + linear pixel index * 8, modulo 2^26.
  function automatic logic [25:0] ref_addr(input logic [25:0] b, input int unsigned x,
                                           input int unsigned y);
    longint unsigned t;
    t = longint'(b) + (longint'(x) + longint'(HRES) * longint'(y)) * 8;
    return t[25:0];
  endfunction

  task automatic model_accept(input logic [25:0] b, input int unsigned x, input int unsigned y,
                              input logic [31:0] c);
    if (x < HRES && y < VRES) exp_q.push_back({ref_addr(b, x, y), c});
  endtask

  task automatic model_clear(input logic [25:0] b, input logic [31:0] c);
    for (int k = 0; k < int'(TOTAL); k++) exp_q.push_back({ref_addr(b, k, 0), c});
  endtask

  // Bus monitor: every completed write is checked against the model in order.
  logic        stall_prev = 1'b0;
  logic [25:0] st_addr;
  logic [31:0] st_data;
  initial begin
    logic [57:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("stall_hold", {m_write, m_addr, m_data}, {1'b1, st_addr, st_data});
        stall_prev = m_write && m_wait;
        st_addr    = m_addr;
        st_data    = m_data;
        if (m_write && !m_wait) begin
          n_wr++;
          last_cyc  = cyc;
          last_addr = m_addr;
          last_data = m_data;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: got %h/%h, expected none", m_addr, m_data);
          end else begin
            e = exp_q.pop_front();
            chk("write", {6'd0, m_addr, m_data}, {6'd0, e});
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_pixel(input logic [25:0] b, input int unsigned x, input int unsigned y,
                            input logic [31:0] c);
    bit acc = 0;
    base = b; pix_x = 10'(x); pix_y = 9'(y); pix_color = c; pix_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk); #1;
      if (pix_ready) begin
        acc = 1;
        model_accept(b, x, y, c);
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    chk("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_idle(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (!busy) begin
        at = cyc;
        break;
      end
    end
    chk("idle_reached", 64'(at >= 0), 64'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [25:0] b;
    int unsigned x;
    int unsigned y;
    logic [31:0] c;
    bit          ok;
    logic [25:0] ea;
  } vec_t;

  vec_t vt[9];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int at, w0, r, acc_cnt;
    bit saw_busy, accd;

    vt[0] = '{26'h0100000, 3,    2,   32'h00FF0000, 1, 26'h0102818};
    vt[1] = '{26'h0000000, 0,    0,   32'h11223344, 1, 26'h0000000};
    vt[2] = '{26'h0000000, 639,  3,   32'h00ABCDEF, 1, 26'h0004FF8};
    vt[3] = '{26'h3FFFFF8, 1,    0,   32'hDEADBEEF, 1, 26'h0000000};
    vt[4] = '{26'h0000123, 5,    1,   32'h00010203, 1, 26'h000154B};
    vt[5] = '{26'h0000000, 640,  0,   32'h00777777, 0, 26'h0};
    vt[6] = '{26'h0000000, 0,    4,   32'h00888888, 0, 26'h0};
    vt[7] = '{26'h0000000, 1023, 511, 32'h00999999, 0, 26'h0};
    vt[8] = '{26'h2000000, 100,  3,   32'h00C0FFEE, 1, 26'h2003F20};

    rst_n = 1'b0; base = '0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
    clear_start = 1'b0; clear_color = '0; m_wait = 1'b0;

    #3;
    chk("rst_write", 64'(m_write), 64'd0);
    chk("rst_addr", 64'(m_addr), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(pix_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_ready", 64'(pix_ready), 64'd1);
    @(posedge clk); #1;

    // Single pixels against hand-computed addresses.
    for (int i = 0; i < 9; i++) begin
      w0 = n_wr;
      saw_busy = 0;
      send_pixel(vt[i].b, vt[i].x, vt[i].y, vt[i].c);
      if (!vt[i].ok) begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk); #1;
          if (busy) saw_busy = 1;
        end
        chk($sformatf("vec%0d_busy", i), 64'(saw_busy), 64'd0);
        @(posedge clk); #1;
      end
      wait_idle(50, at);
      chk($sformatf("vec%0d_nwr", i), 64'(n_wr - w0), 64'(vt[i].ok));
      if (vt[i].ok) chk($sformatf("vec%0d_write", i), {6'd0, last_addr, last_data},
                        {6'd0, vt[i].ea, vt[i].c});
    end

    // Five-cycle stall holds one write steady.
    w0 = n_wr;
    m_wait = 1'b1;
    send_pixel(26'h40, 7, 0, 32'h0000CAFE);
    at = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (m_write) begin
        at = i;
        break;
      end
    end
    chk("stall_write_seen", 64'(at >= 0), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("stall5", {5'd0, m_write, m_addr, m_data}, {5'd0, 1'b1, 26'h78, 32'h0000CAFE});
    end
    @(posedge clk); #1;
    m_wait = 1'b0;
    wait_idle(50, at);
    chk("stall_completions", 64'(n_wr - w0), 64'd1);

    // Fill the FIFO behind a stuck slave.
    m_wait = 1'b1;
    acc_cnt = 0;
    base = 26'h0010000;
    pix_valid = 1'b1;
    for (int i = 0; i < 20 && acc_cnt < 9; i++) begin
      pix_x = 10'(acc_cnt * 11); pix_y = 9'(acc_cnt % 4); pix_color = 32'h100 + 32'(acc_cnt);
      @(negedge clk); #1;
      if (pix_ready) begin
        model_accept(base, acc_cnt * 11, acc_cnt % 4, 32'h100 + 32'(acc_cnt));
        acc_cnt++;
      end
      @(posedge clk); #1;
    end
    chk("accepts_until_full", 64'(acc_cnt), 64'd8);
    chk("ready_when_full", 64'(pix_ready), 64'd0);
    pix_valid = 1'b0;
    w0 = n_wr;
    m_wait = 1'b0;
    @(negedge clk); #1;
    r = cyc;
    wait_idle(50, at);
    chk("drain_count", 64'(n_wr - w0), 64'd8);
    chk("drain_back_to_back", 64'(last_cyc - r), 64'd7);

    // Two queued pixels, the second alongside clear_start, then the frame fill.
    w0 = n_wr;
    m_wait = 1'b1;
    send_pixel(26'h0, 10, 1, 32'h00000001);
    base = 26'h0; pix_x = 10'd20; pix_y = 9'd2; pix_color = 32'h2; pix_valid = 1'b1;
    clear_start = 1'b1; clear_color = 32'hAA;
    @(negedge clk); #1;
    chk("ready_with_clear", 64'(pix_ready), 64'd1);
    if (pix_ready) model_accept(26'h0, 20, 2, 32'h2);
    model_clear(26'h0, 32'hAA);
    @(posedge clk); #1;
    pix_valid = 1'b0; clear_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 m_wait = 1'b0;
    repeat (30) @(posedge clk);
    #1 clear_start = 1'b1; clear_color = 32'h55;
    base = 26'h1234;
    @(negedge clk); #1;
    chk("ready_in_clear", 64'(pix_ready), 64'd0);
    @(posedge clk); #1;
    clear_start = 1'b0;
    wait_idle(int'(TOTAL) + 200, at);
    chk("clear_count", 64'(n_wr - w0), 64'(TOTAL + 2));
    chk("clear_last_write", {6'd0, last_addr, last_data}, {6'd0, 26'h0004FF8, 32'hAA});
    chk("busy_falls_next", 64'(at - last_cyc), 64'd1);
    chk("clear_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of the fill.
    clear_start = 1'b1; clear_color = 32'h00000055; base = 26'h0200000;
    @(negedge clk); #1;
    model_clear(26'h0200000, 32'h55);
    @(posedge clk); #1;
    clear_start = 1'b0;
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (m_write && m_addr == 26'h0200320) begin
        at = i;
        break;
      end
    end
    chk("fill_k100_seen", 64'(at >= 0), 64'd1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_write", 64'(m_write), 64'd0);
    chk("midrst_addr", 64'(m_addr), 64'd0);
    chk("midrst_data", 64'(m_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(pix_ready), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    send_pixel(26'h0000100, 1, 1, 32'h00123456);
    wait_idle(50, at);
    chk("post_rst_pixel", {6'd0, last_addr, last_data}, {6'd0, 26'h0001508, 32'h00123456});

    // Randomised traffic with a randomly stalling slave.
    accd = 0;
    for (int i = 0; i < 1500; i++) begin
      if (accd) pix_valid = 1'b0;
      accd = 0;
      m_wait = ($urandom_range(0, 3) == 0);
      if (!pix_valid && $urandom_range(0, 1) == 1) begin
        base      = 26'($urandom);
        pix_x     = 10'($urandom_range(0, 700));
        pix_y     = 9'($urandom_range(0, 5));
        pix_color = $urandom;
        pix_valid = 1'b1;
      end
      @(negedge clk); #1;
      if (pix_valid && pix_ready) begin
        model_accept(base, pix_x, pix_y, pix_color);
        accd = 1;
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    m_wait = 1'b0;
    wait_idle(100, at);
    chk("random_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
